// File: rtl/mux_stream_sel.sv
// ---------------------------------------------------------------------------
// mux_stream_sel
//
// Purpose:
//    N-channel, W-bit stream selector with one registered output stage.
//    Each input channel has a valid/ready handshake. At most one channel is
//    forwarded per cycle into the output register. The channel is picked
//    either by a fixed select index or by round-robin arbitration. This
//    block sits between the pixel-source buffers and the filter datapath.
//
// Parameters:
//    WIDTH    - data width per channel in bits
//    CHANNELS - number of input channels (2..16)
//    SEL_W    - select / channel-index width, 2**SEL_W >= CHANNELS
//
// Ports:
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_data    in   packed channel data, channel i at [i*WIDTH +: WIDTH]
//    in_valid   in   per-channel valid
//    in_ready   out  per-channel ready (combinational)
//    sel        in   channel index used in fixed mode
//    rr_mode    in   0 = fixed select, 1 = round-robin
//    out_data   out  registered selected data
//    out_chan   out  registered index of the channel held in out_data
//    out_valid  out  output register holds a word
//    out_ready  in   downstream accepts the word
//
// Optional feature (macro MUX_STREAM_CNT_EN):
//    cnt_clr    in   synchronous clear of xfer_cnt (wins over a handshake)
//    xfer_cnt   out  saturating 16-bit count of output handshakes
//    With the macro undefined neither port nor the counter exists.
// ---------------------------------------------------------------------------
module mux_stream_sel #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      rr_mode,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef MUX_STREAM_CNT_EN
   ,
   input  logic                      cnt_clr,
   output logic [15:0]               xfer_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [SEL_W-1:0]   out_chan_q, out_chan_d;
   logic [SEL_W-1:0]   rr_ptr_q,   rr_ptr_d;

   logic [SEL_W-1:0]   chosen;
   logic               chosen_ok;
   logic               can_load;
   logic               accept;
   logic [WIDTH-1:0]   chosen_data;

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

   // The output register can take a new word when it is empty or when the
   // word it holds leaves in this same cycle.
   assign can_load = !out_valid || out_ready;

   // Channel choice. Fixed mode takes sel as-is and flags an out-of-range
   // index as "no channel". Round-robin scans upward from rr_ptr and wraps:
   // the first pass covers rr_ptr..CHANNELS-1, the second pass 0..rr_ptr-1,
   // so the loop indices stay constant and no modulo arithmetic is needed.
   always_comb begin
      chosen    = '0;
      chosen_ok = 1'b0;
      if (!rr_mode) begin
         chosen    = sel;
         chosen_ok = (int'(sel) < CHANNELS);
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!chosen_ok && in_valid[i] && (i >= int'(rr_ptr_q))) begin
               chosen    = SEL_W'(i);
               chosen_ok = 1'b1;
            end
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (!chosen_ok && in_valid[i] && (i < int'(rr_ptr_q))) begin
               chosen    = SEL_W'(i);
               chosen_ok = 1'b1;
            end
         end
      end
   end

   // Ready goes only to the chosen channel and is forced low while reset is
   // asserted, because the empty output stage would otherwise advertise
   // space during reset.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = rst_n && can_load && chosen_ok && (int'(chosen) == i);
      end
   end

   // At most one ready bit is set, so the accept is simply any channel that
   // is both valid and ready.
   assign accept = |(in_valid & in_ready);

   // Data mux for the chosen channel; out-of-range indices match nothing and
   // leave zero, which is never loaded because accept is low then.
   always_comb begin
      chosen_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(chosen) == i) begin
            chosen_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic for the output stage. A simultaneous accept and
   // downstream take keep the stage FULL, giving one word per cycle.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_chan_d = out_chan_q;
      rr_ptr_d   = rr_ptr_q;

      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (out_ready && !accept) begin
               state_d = EMPTY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      if (accept) begin
         out_data_d = chosen_data;
         out_chan_d = chosen;
      end

      // Only round-robin transfers advance the pointer; fixed-mode traffic
      // leaves the arbitration history untouched.
      if (accept && rr_mode) begin
         if (chosen == SEL_W'(CHANNELS - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = chosen + SEL_W'(1);
         end
      end
   end

   // Output stage and arbitration pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_chan_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_chan_q <= out_chan_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

`ifdef MUX_STREAM_CNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;
   logic        out_hs;

   assign out_hs   = out_valid && out_ready;
   assign xfer_cnt = xfer_cnt_q;

   // Handshake counter: clear has priority, otherwise count up and stick at
   // all-ones.
   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (cnt_clr) begin
         xfer_cnt_d = '0;
      end else if (out_hs && (xfer_cnt_q != 16'hFFFF)) begin
         xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_mux_stream_sel.sv
// ---------------------------------------------------------------------------
// tb_mux_stream_sel
//
// Directed testbench for mux_stream_sel. A 4-channel instance carries most
// scenarios; a 3-channel instance covers the out-of-range fixed select.
// Expected values are written out by hand in each scenario task.
// ---------------------------------------------------------------------------
module tb_mux_stream_sel;

   logic         clk;
   logic         rst_n;

   logic [31:0]  ch [4];
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [1:0]   sel;
   logic         rr_mode;
   logic [31:0]  out_data;
   logic [1:0]   out_chan;
   logic         out_valid;
   logic         out_ready;

   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [1:0]   sel3;
   logic [31:0]  out_data3;
   logic [1:0]   out_chan3;
   logic         out_valid3;
   logic         out_ready3;

`ifdef MUX_STREAM_CNT_EN
   logic         cnt_clr;
   logic [15:0]  xfer_cnt;
   logic         cnt_clr3;
   logic [15:0]  xfer_cnt3;
`endif

   int total;
   int bad;

   assign in_data  = {ch[3], ch[2], ch[1], ch[0]};
   assign in_data3 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

   mux_stream_sel #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .rr_mode   (rr_mode),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_STREAM_CNT_EN
      ,
      .cnt_clr   (cnt_clr),
      .xfer_cnt  (xfer_cnt)
`endif
   );

   mux_stream_sel #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .sel       (sel3),
      .rr_mode   (1'b0),
      .out_data  (out_data3),
      .out_chan  (out_chan3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
`ifdef MUX_STREAM_CNT_EN
      ,
      .cnt_clr   (cnt_clr3),
      .xfer_cnt  (xfer_cnt3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and land 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [1:0] s,
                                input logic rr, input logic ordy);
      in_valid  = v;
      sel       = s;
      rr_mode   = rr;
      out_ready = ordy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(4'hF, 2'd0, 1'b0, 1'b1);
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0h exp=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_data got=%0h exp=0", out_data); end
      total++; if (out_chan !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_chan got=%0h exp=0", out_chan); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready got=%0h exp=0", in_ready); end
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL post_reset_in_ready got=%0h exp=1", in_ready); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_accept_valid got=%0h exp=1", out_valid); end
      total++; if (out_data !== 32'hA5A5_0000) begin bad++; $display("[TB] FAIL first_accept_data got=%0h exp=a5a50000", out_data); end
      applyStimulus(4'h0, 2'd0, 1'b0, 1'b1);
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_after_reset got=%0h exp=0", out_valid); end
   endtask

   task automatic test_fixed();
      applyStimulus(4'b0100, 2'd2, 1'b0, 1'b1);
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL fixed_in_ready got=%0h exp=4", in_ready); end
      step();
      total++; if (out_data !== 32'hA5A5_0002) begin bad++; $display("[TB] FAIL fixed_out_data got=%0h exp=a5a50002", out_data); end
      total++; if (out_chan !== 2'd2) begin bad++; $display("[TB] FAIL fixed_out_chan got=%0h exp=2", out_chan); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL fixed_out_valid got=%0h exp=1", out_valid); end
      applyStimulus(4'b0000, 2'd2, 1'b0, 1'b1);
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL fixed_ready_no_valid got=%0h exp=4", in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL fixed_drain got=%0h exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      applyStimulus(4'b0100, 2'd2, 1'b0, 1'b0);
      step();
      total++; if (out_data !== 32'hA5A5_0002) begin bad++; $display("[TB] FAIL bp_load got=%0h exp=a5a50002", out_data); end
      ch[2] = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%0h exp=0", c, in_ready); end
         step();
         total++; if (out_data !== 32'hA5A5_0002) begin bad++; $display("[TB] FAIL bp_hold_data cyc=%0d got=%0h exp=a5a50002", c, out_data); end
         total++; if (out_chan !== 2'd2) begin bad++; $display("[TB] FAIL bp_hold_chan cyc=%0d got=%0h exp=2", c, out_chan); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%0h exp=1", c, out_valid); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release_ready got=%0h exp=4", in_ready); end
      step();
      total++; if (out_data !== 32'h1234_5678) begin bad++; $display("[TB] FAIL bp_next_word got=%0h exp=12345678", out_data); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_no_bubble got=%0h exp=1", out_valid); end
      in_valid = 4'b0000;
      ch[2]    = 32'hA5A5_0002;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0h exp=0", out_valid); end
   endtask

   task automatic test_round_robin();
      int exp_all [5];
      int exp_odd [4];
      exp_all = '{0, 1, 2, 3, 0};
      exp_odd = '{1, 3, 1, 3};
      applyStimulus(4'hF, 2'd0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (in_ready !== (4'b0001 << exp_all[k])) begin bad++; $display("[TB] FAIL rr_all_ready k=%0d got=%0h exp=%0h", k, in_ready, 4'b0001 << exp_all[k]); end
         step();
         total++; if (out_chan !== 2'(exp_all[k])) begin bad++; $display("[TB] FAIL rr_all_chan k=%0d got=%0d exp=%0d", k, out_chan, exp_all[k]); end
         total++; if (out_data !== ch[exp_all[k]]) begin bad++; $display("[TB] FAIL rr_all_data k=%0d got=%0h exp=%0h", k, out_data, ch[exp_all[k]]); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_all_valid k=%0d got=%0h exp=1", k, out_valid); end
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         total++; if (out_chan !== 2'(exp_odd[k])) begin bad++; $display("[TB] FAIL rr_odd_chan k=%0d got=%0d exp=%0d", k, out_chan, exp_odd[k]); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_odd_valid k=%0d got=%0h exp=1", k, out_valid); end
      end
      in_valid = 4'b0000;
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL rr_none_ready got=%0h exp=0", in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_drain got=%0h exp=0", out_valid); end
      rr_mode = 1'b0;
   endtask

   task automatic test_invalid_sel();
      sel3       = 2'd3;
      in_valid3  = 3'b111;
      out_ready3 = 1'b1;
      #1;
      total++; if (in_ready3 !== 3'b000) begin bad++; $display("[TB] FAIL badsel_ready got=%0h exp=0", in_ready3); end
      step();
      step();
      total++; if (out_valid3 !== 1'b0) begin bad++; $display("[TB] FAIL badsel_valid got=%0h exp=0", out_valid3); end
      sel3 = 2'd2;
      #1;
      total++; if (in_ready3 !== 3'b100) begin bad++; $display("[TB] FAIL topsel_ready got=%0h exp=4", in_ready3); end
      step();
      total++; if (out_chan3 !== 2'd2) begin bad++; $display("[TB] FAIL topsel_chan got=%0h exp=2", out_chan3); end
      total++; if (out_data3 !== 32'hC0DE_0002) begin bad++; $display("[TB] FAIL topsel_data got=%0h exp=c0de0002", out_data3); end
      in_valid3 = 3'b000;
      step();
   endtask

   task automatic test_async_reset();
      applyStimulus(4'b0010, 2'd1, 1'b0, 1'b0);
      step();
      total++; if (out_chan !== 2'd1) begin bad++; $display("[TB] FAIL ar_loaded_chan got=%0h exp=1", out_chan); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid_drop got=%0h exp=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL ar_data_clear got=%0h exp=0", out_data); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL ar_in_ready got=%0h exp=0", in_ready); end
      applyStimulus(4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      rst_n = 1'b1;
      step();
   endtask

`ifdef MUX_STREAM_CNT_EN
   task automatic test_counter();
      applyStimulus(4'b0000, 2'd0, 1'b0, 1'b1);
      cnt_clr = 1'b0;
      rst_n   = 1'b0;
      step();
      total++; if (xfer_cnt !== 16'd0) begin bad++; $display("[TB] FAIL cnt_reset got=%0d exp=0", xfer_cnt); end
      rst_n    = 1'b1;
      in_valid = 4'b0001;
      for (int k = 0; k < 6; k++) step();
      total++; if (xfer_cnt !== 16'd5) begin bad++; $display("[TB] FAIL cnt_five got=%0d exp=5", xfer_cnt); end
      cnt_clr = 1'b1;
      step();
      total++; if (xfer_cnt !== 16'd0) begin bad++; $display("[TB] FAIL cnt_clr_hs got=%0d exp=0", xfer_cnt); end
      cnt_clr  = 1'b0;
      in_valid = 4'b0000;
      step();
      total++; if (xfer_cnt !== 16'd1) begin bad++; $display("[TB] FAIL cnt_after_clr got=%0d exp=1", xfer_cnt); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      ch[0] = 32'hA5A5_0000;
      ch[1] = 32'hA5A5_0001;
      ch[2] = 32'hA5A5_0002;
      ch[3] = 32'hA5A5_0003;
      sel3       = 2'd0;
      in_valid3  = 3'b000;
      out_ready3 = 1'b1;
`ifdef MUX_STREAM_CNT_EN
      cnt_clr  = 1'b0;
      cnt_clr3 = 1'b0;
`endif
      test_reset();
      test_fixed();
      test_backpressure();
      test_round_robin();
      test_invalid_sel();
      test_async_reset();
`ifdef MUX_STREAM_CNT_EN
      test_counter();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
